// File: rtl/ysyx_22050854_axi_line_master_if.sv
// Bundle of the cache-side request/response and AXI4 channel signals of the line master.
// The master modport is the DUT view; the slave modport is the cache plus memory side.
interface ysyx_22050854_axi_line_master_if;
   logic         req_valid;
   logic         req_ready;
   logic         req_write;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;
   logic         resp_valid;
   logic [127:0] resp_rdata;
   logic         resp_err;

   logic         arvalid;
   logic         arready;
   logic [31:0]  araddr;
   logic [3:0]   arid;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;

   logic         rvalid;
   logic         rready;
   logic [63:0]  rdata;
   logic [1:0]   rresp;
   logic [3:0]   rid;
   logic         rlast;

   logic         awvalid;
   logic         awready;
   logic [31:0]  awaddr;
   logic [3:0]   awid;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;

   logic         wvalid;
   logic         wready;
   logic [63:0]  wdata;
   logic [7:0]   wstrb;
   logic         wlast;

   logic         bvalid;
   logic         bready;
   logic [1:0]   bresp;
   logic [3:0]   bid;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rdata, rresp, rid, rlast,
      output rready,
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      output rvalid, rdata, rresp, rid, rlast,
      input  rready,
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready
   );
endinterface

// File: rtl/ysyx_22050854_axi_line_master.sv
// AXI4 master moving one 16-byte line per request as a 2-beat INCR burst (refill or writeback).
// Optional response checking: define YSYX_22050854_AXI_LINE_MASTER_RESP_CHECK_EN.
module ysyx_22050854_axi_line_master #(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic        clock,
   input  logic        reset,
   ysyx_22050854_axi_line_master_if.master io_bus,
   output logic [2:0]  o_dbg_state
);
   // Every channel transfers on a cycle where valid && ready are both high at posedge;
   // a raised valid holds its payload stable until that handshake.
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;

   logic [2:0]   r_state;
   logic [27:0]  r_addr;
   logic [127:0] r_wline;
   logic [63:0]  r_rlo;
   logic [127:0] r_rdata;
   logic         r_beat;
   logic         r_err;
   logic         r_resp_valid;
   logic         r_resp_err;

   logic         w_r_end;
   logic         w_r_err;
   logic         w_b_err;

`ifdef YSYX_22050854_AXI_LINE_MASTER_RESP_CHECK_EN
   // A missing rlast on beat1 still terminates the burst; it is reported as an error.
   assign w_r_end = io_bus.rlast | r_beat;
   assign w_r_err = (io_bus.rresp != 2'b00) | (io_bus.rid != AXI_ID) |
                    (io_bus.rlast != r_beat);
   assign w_b_err = (io_bus.bresp != 2'b00) | (io_bus.bid != AXI_ID);
   logic w_unused;
   assign w_unused = ^io_bus.req_addr[3:0];
`else
   assign w_r_end = io_bus.rlast;
   assign w_r_err = 1'b0;
   assign w_b_err = 1'b0;
   logic w_unused;
   assign w_unused = ^{io_bus.req_addr[3:0], io_bus.rresp, io_bus.rid,
                       io_bus.bresp, io_bus.bid};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_addr       <= 28'd0;
         r_wline      <= 128'd0;
         r_rlo        <= 64'd0;
         r_rdata      <= 128'd0;
         r_beat       <= 1'b0;
         r_err        <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         case (r_state)
            S_IDLE: if (io_bus.req_valid) begin
               r_addr  <= io_bus.req_addr[31:4];
               r_wline <= io_bus.req_wdata;
               r_rlo   <= 64'd0;
               r_beat  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= io_bus.req_write ? S_AW : S_AR;
            end
            S_AR: if (io_bus.arready) r_state <= S_R;
            S_R: if (io_bus.rvalid) begin
               r_err <= r_err | w_r_err;
               if (w_r_end) begin
                  // A short burst leaves the upper half of the line zero.
                  r_rdata      <= r_beat ? {io_bus.rdata, r_rlo} : {64'd0, io_bus.rdata};
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= r_err | w_r_err;
                  r_beat       <= 1'b0;
                  r_state      <= S_IDLE;
               end else begin
                  if (!r_beat) r_rlo <= io_bus.rdata;
                  r_beat <= ~r_beat;
               end
            end
            S_AW: if (io_bus.awready) r_state <= S_W;
            S_W: if (io_bus.wready) begin
               r_beat <= ~r_beat;
               if (r_beat) r_state <= S_B;
            end
            S_B: if (io_bus.bvalid) begin
               r_resp_valid <= 1'b1;
               r_resp_err   <= r_err | w_b_err;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.req_ready  = (r_state == S_IDLE);
   assign io_bus.resp_valid = r_resp_valid;
   assign io_bus.resp_rdata = r_rdata;
   assign io_bus.resp_err   = r_resp_err;

   assign io_bus.arvalid = (r_state == S_AR);
   assign io_bus.araddr  = {r_addr, 4'h0};
   assign io_bus.arid    = AXI_ID;
   assign io_bus.arlen   = 8'd1;
   assign io_bus.arsize  = 3'd3;
   assign io_bus.arburst = 2'b01;
   assign io_bus.rready  = (r_state == S_R);

   assign io_bus.awvalid = (r_state == S_AW);
   assign io_bus.awaddr  = {r_addr, 4'h0};
   assign io_bus.awid    = AXI_ID;
   assign io_bus.awlen   = 8'd1;
   assign io_bus.awsize  = 3'd3;
   assign io_bus.awburst = 2'b01;

   assign io_bus.wvalid = (r_state == S_W);
   assign io_bus.wdata  = r_beat ? r_wline[127:64] : r_wline[63:0];
   assign io_bus.wstrb  = 8'hFF;
   assign io_bus.wlast  = r_beat;
   assign io_bus.bready = (r_state == S_B);

   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ysyx_22050854_axi_line_master.sv
// Directed bench for the AXI line master: refill, writeback, stalls, rvalid gaps, reset, errors.
// Inputs change and outputs are sampled on the negedge, away from the active posedge.
module tb_ysyx_22050854_axi_line_master;
   localparam logic [3:0] AXI_ID = 4'd0;
`ifdef YSYX_22050854_AXI_LINE_MASTER_RESP_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   localparam logic [63:0]  D1   = 64'h1111_1111_1111_1111;
   localparam logic [63:0]  D2   = 64'h2222_2222_2222_2222;
   localparam logic [63:0]  DA   = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0]  DB   = 64'hBBBB_BBBB_BBBB_BBBB;
   localparam logic [63:0]  D3   = 64'h3333_3333_3333_3333;
   localparam logic [63:0]  D4   = 64'h4444_4444_4444_4444;
   localparam logic [127:0] LINE12 = {D2, D1};

   logic       clock;
   logic       reset;
   logic [2:0] dbg_state;
   int         checks;
   int         errors;

   ysyx_22050854_axi_line_master_if bus ();

   ysyx_22050854_axi_line_master #(.AXI_ID(AXI_ID)) dut (
      .clock       (clock),
      .reset       (reset),
      .io_bus      (bus.master),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic accept(input logic wr, input logic [31:0] a, input logic [127:0] d);
      chk("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(negedge clock);
      bus.req_valid = 1'b0;
   endtask

   task automatic ar_hs();
      bus.arready = 1'b1;
      @(negedge clock);
      bus.arready = 1'b0;
   endtask

   task automatic aw_hs();
      bus.awready = 1'b1;
      @(negedge clock);
      bus.awready = 1'b0;
   endtask

   task automatic r_beat(input logic [63:0] d, input logic last, input logic [1:0] resp);
      chk("rready", bus.rready, 1'b1);
      bus.rvalid = 1'b1;
      bus.rdata  = d;
      bus.rlast  = last;
      bus.rresp  = resp;
      @(negedge clock);
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
   endtask

   task automatic w_beats(input logic [63:0] hi);
      chk("w0_wvalid", bus.wvalid, 1'b1);
      bus.wready = 1'b1;
      @(negedge clock);
      chk("w1_wdata", bus.wdata, hi);
      chk("w1_wlast", bus.wlast, 1'b1);
      @(negedge clock);
      bus.wready = 1'b0;
      chk("b_bready", bus.bready, 1'b1);
      chk("b_wvalid", bus.wvalid, 1'b0);
   endtask

   task automatic b_hs(input logic [3:0] id);
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b00;
      bus.bid    = id;
      @(negedge clock);
      bus.bvalid = 1'b0;
      bus.bid    = AXI_ID;
   endtask

   task automatic done_chk(input string tag, input logic [127:0] line, input logic err);
      chk({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
      chk({tag, "_resp_rdata"}, bus.resp_rdata, line);
      chk({tag, "_resp_err"}, bus.resp_err, err);
      @(negedge clock);
      chk({tag, "_pulse_end"}, bus.resp_valid, 1'b0);
   endtask

   // scenario sequence
   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 128'd0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 64'd0; bus.rresp = 2'b00;
      bus.rid = AXI_ID; bus.rlast = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
      bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = AXI_ID;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst_state", dbg_state, 3'd0);
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'd0);
      chk("rst_resp", {bus.resp_valid, bus.resp_err}, 2'd0);
      chk("rst_rdata", bus.resp_rdata, 128'd0);

      // 1: plain refill
      accept(1'b0, 32'h8000_1234, 128'd0);
      chk("t1_arvalid", bus.arvalid, 1'b1);
      chk("t1_araddr", bus.araddr, 32'h8000_1230);
      chk("t1_arfields", {bus.arid, bus.arlen, bus.arsize, bus.arburst}, {AXI_ID, 8'd1, 3'd3, 2'b01});
      chk("t1_req_ready", bus.req_ready, 1'b0);
      ar_hs();
      chk("t1_arvalid_drop", bus.arvalid, 1'b0);
      r_beat(D1, 1'b0, 2'b00);
      chk("t1_mid_resp", bus.resp_valid, 1'b0);
      r_beat(D2, 1'b1, 2'b00);
      done_chk("t1", LINE12, 1'b0);
      chk("t1_rready_idle", bus.rready, 1'b0);

      // 2: writeback
      accept(1'b1, 32'h8000_0040, {DA, DB});
      chk("t2_awvalid", bus.awvalid, 1'b1);
      chk("t2_awaddr", bus.awaddr, 32'h8000_0040);
      chk("t2_awfields", {bus.awid, bus.awlen, bus.awsize, bus.awburst}, {AXI_ID, 8'd1, 3'd3, 2'b01});
      chk("t2_no_w_before_aw", bus.wvalid, 1'b0);
      aw_hs();
      chk("t2_w0_wdata", bus.wdata, DB);
      chk("t2_w0_wlast", bus.wlast, 1'b0);
      chk("t2_wstrb", bus.wstrb, 8'hFF);
      w_beats(DA);
      b_hs(AXI_ID);
      done_chk("t2", LINE12, 1'b0);

      // 3+4: arready stall with req_valid ignored, then rvalid gaps
      accept(1'b0, 32'h0000_10F8, 128'd0);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h1234_5670;
      for (int i = 0; i < 5; i++) begin
         chk("t3_ar_hold", {bus.arvalid, bus.araddr}, {1'b1, 32'h0000_10F0});
         chk("t3_ar_req_ready", {bus.req_ready, bus.rready, bus.awvalid}, 3'd0);
         @(negedge clock);
      end
      bus.req_valid = 1'b0;
      ar_hs();
      for (int i = 0; i < 3; i++) begin
         chk("t4_gap0", {bus.rready, bus.resp_valid}, 2'b10);
         @(negedge clock);
      end
      r_beat(D3, 1'b0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         chk("t4_gap1", {bus.rready, bus.resp_valid}, 2'b10);
         @(negedge clock);
      end
      r_beat(D4, 1'b1, 2'b00);
      done_chk("t4", {D4, D3}, 1'b0);
      chk("t4_no_second_pulse", bus.resp_valid, 1'b0);

      // 3: awready and wready stalls
      accept(1'b1, 32'h8000_0080, {D2, D1});
      for (int i = 0; i < 5; i++) begin
         chk("t3_aw_hold", {bus.awvalid, bus.awaddr, bus.wvalid}, {1'b1, 32'h8000_0080, 1'b0});
         chk("t3_aw_req_ready", bus.req_ready, 1'b0);
         @(negedge clock);
      end
      aw_hs();
      for (int i = 0; i < 5; i++) begin
         chk("t3_w_hold", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, 1'b0, D1});
         chk("t3_w_bready", {bus.req_ready, bus.bready}, 2'd0);
         @(negedge clock);
      end
      w_beats(D2);
      repeat (2) begin
         chk("t3_b_wait", {bus.bready, bus.resp_valid}, 2'b10);
         @(negedge clock);
      end
      b_hs(AXI_ID);
      done_chk("t3w", {D4, D3}, 1'b0);

      // 5: reset after beat0 of a refill
      accept(1'b0, 32'h8000_2000, 128'd0);
      ar_hs();
      r_beat(D1, 1'b0, 2'b00);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("t5_state", dbg_state, 3'd0);
      chk("t5_req_ready", bus.req_ready, 1'b1);
      chk("t5_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'd0);
      chk("t5_rdata", bus.resp_rdata, 128'd0);
      chk("t5_resp", {bus.resp_valid, bus.resp_err}, 2'd0);
      @(negedge clock);
      chk("t5_no_resp", bus.resp_valid, 1'b0);
      accept(1'b0, 32'h8000_2000, 128'd0);
      chk("t5_araddr", bus.araddr, 32'h8000_2000);
      ar_hs();
      r_beat(DB, 1'b0, 2'b00);
      r_beat(DA, 1'b1, 2'b00);
      done_chk("t5", {DA, DB}, 1'b0);

      // 6: error stimuli
      accept(1'b0, 32'h8000_3000, 128'd0);
      ar_hs();
      r_beat(D1, 1'b0, 2'b00);
      r_beat(D2, 1'b1, 2'b10);
      done_chk("t6_rresp", LINE12, EXP_ERR);

      accept(1'b0, 32'h8000_3010, 128'd0);
      ar_hs();
      r_beat(D3, 1'b1, 2'b00);
      done_chk("t6_short", {64'd0, D3}, EXP_ERR);
      chk("t6_short_idle", {bus.req_ready, bus.rready}, 2'b10);

      accept(1'b1, 32'h8000_3020, {DA, DB});
      aw_hs();
      chk("t6_w0_wdata", bus.wdata, DB);
      w_beats(DA);
      b_hs(AXI_ID + 4'd1);
      done_chk("t6_bid", {64'd0, D3}, EXP_ERR);

      accept(1'b0, 32'h8000_3030, 128'd0);
      ar_hs();
      r_beat(D4, 1'b0, 2'b00);
      r_beat(D1, 1'b1, 2'b00);
      done_chk("t6_clean", {D1, D4}, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
